sync_fifo: RTL and testbench
============================

# sync_fifo

Parametrised single-clock FIFO, the next generation of the team's basic FIFO. It adds asynchronous active-low reset, a selectable first-word-fall-through (FWFT) read mode, an occupancy count, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags. It sits between producer and consumer logic in one clock domain and is the default buffering primitive for new datapaths.

## Interface
- DEPTH, 8: number of entries; power of two, at least 2.
- WIDTH, 64: data width in bits.
- FWFT, 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
- AFULL_LVL, DEPTH-2: almost_full asserts when count >= AFULL_LVL; legal range 1..DEPTH.
- AEMPTY_LVL, 2: almost_empty asserts when count <= AEMPTY_LVL; legal range 0..DEPTH-1.
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  reset; asynchronous, active-low. Asserts immediately, deasserts synchronously by the integrator's synchroniser.
- wen  in  1  write request.
- din  in  WIDTH  write data.
- ren  in  1  read request (FWFT=1: pop/acknowledge of the head word).
- clr_err  in  1  clears overflow and underflow.
- dout  out  WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_LVL.
- almost_empty  out  1  count <= AEMPTY_LVL.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

## Operation
- Write and read pointers are $clog2(DEPTH)+1 bits wide; the low bits index storage and the top bit is the wrap bit. count = wptr - rptr, modulo 2^($clog2(DEPTH)+1).
- empty is asserted when wptr == rptr. full is asserted when the wrap bits differ and the low bits are equal. All flags and count are combinational from the registered pointers only, never from wen/ren.
- Write is accepted iff wen && !full. The entry at wptr is stored and wptr increments, wrapping naturally.
- Read is accepted iff ren && !empty. rptr increments.
- Simultaneous accepted read and write leave count unchanged. A write while full is rejected even if ren=1 in the same cycle.
- FWFT=0: on an accepted read, dout registers the entry at rptr. Otherwise dout holds its value.
- FWFT=1: dout = storage[rptr] combinationally while !empty, and 0 while empty. An accepted ren advances to the next word.
- overflow is set on a cycle with wen && full. underflow is set on a cycle with ren && empty. Both are cleared on clr_err. Set wins over clear in the same cycle. Rejected accesses do not change pointers, storage or dout.
- Reset (reset=0, asynchronous) values:
  - wptr = rptr = 0
  - dout = 0
  - overflow = underflow = 0
  - Resulting flags: empty=1, full=0, count=0, almost_empty=1, almost_full=0 (for legal parameters).
- Storage contents are not reset.
- Reset mid-operation discards all contents immediately. No partial write or read completes in the cycle reset asserts.

## Timing
- Write at edge N: count/empty/almost flags update after edge N.
- FWFT=1: the written word is visible on dout after edge N (one-cycle write-to-read latency).
- FWFT=0: the earliest accepted ren is in the cycle after edge N. dout is valid after the following edge (two-cycle write-to-dout latency).
- Read at edge N (FWFT=0): new dout after edge N. Flags update after edge N.
- Sustained throughput is one write and one read per cycle with no bubbles, including at pointer wrap.

## Test plan
- Reset then idle: with DEPTH=8, WIDTH=8, release reset -> empty=1, full=0, count=0, almost_empty=1, dout=0, overflow=underflow=0.
- Fill and drain (FWFT=0): write 0x01..0x08 on consecutive cycles -> full=1, count=8, almost_full asserted from count 6. Then ren for 8 cycles -> dout sequence 0x01..0x08, one per cycle, empty=1 at end.
- Errors: while full, wen with din=0xAA -> overflow=1 and contents unchanged. Then drain and issue ren while empty -> underflow=1, dout unchanged. Pulse clr_err with no new error -> both flags 0. Pulse clr_err together with wen while full -> overflow stays 1.
- FWFT=1: write 0x5A at edge N -> dout=0x5A and empty=0 after edge N with no ren. Then ren -> empty=1, dout=0.
- Simultaneous and wrap: hold count=4, then run wen and ren every cycle for 20 cycles with incrementing data -> count stays 4 and output order is preserved across pointer wrap.
- Async reset mid-stream: assert reset between edges while count=5 -> flags reset immediately without a clock edge. After release, empty=1 and no stale data is read.

Source files
------------

// File: rtl/sync_fifo_if.sv
// Handshake and status bundle between a sync_fifo and its producer/consumer logic.
// The FIFO uses the slave modport; the surrounding logic uses master.
interface sync_fifo_if #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 8
);
   logic                     wen;
   logic [WIDTH-1:0]         din;
   logic                     ren;
   logic                     clr_err;
   logic [WIDTH-1:0]         dout;
   logic                     full;
   logic                     empty;
   logic                     almost_full;
   logic                     almost_empty;
   logic [$clog2(DEPTH):0]   count;
   logic                     overflow;
   logic                     underflow;

   modport master (
      output wen, din, ren, clr_err,
      input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  wen, din, ren, clr_err,
      output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
   );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered or first-word-fall-through read, occupancy
// count, programmable almost flags and sticky overflow/underflow error flags.
module sync_fifo #(
   parameter int DEPTH      = 8,
   parameter int WIDTH      = 64,
   parameter int FWFT       = 0,
   parameter int AFULL_LVL  = DEPTH - 2,
   parameter int AEMPTY_LVL = 2
) (
   input  logic          clk,
   input  logic          reset,
   sync_fifo_if.slave    bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] AFULL_C  = (AW+1)'(AFULL_LVL);
   localparam logic [AW:0] AEMPTY_C = (AW+1)'(AEMPTY_LVL);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr_p0;
   logic [AW:0]      rptr_p0;
   logic [WIDTH-1:0] dout_p1;
   logic             ovf_p0;
   logic             udf_p0;

   logic             full;
   logic             empty;
   logic [AW:0]      count;
   logic             wr_acc;
   logic             rd_acc;
   logic [WIDTH-1:0] head;

   // Flags derive from registered pointers only; the extra wrap bit separates full from empty.
   assign empty  = (wptr_p0 == rptr_p0);
   assign full   = (wptr_p0[AW] != rptr_p0[AW]) && (wptr_p0[AW-1:0] == rptr_p0[AW-1:0]);
   assign count  = wptr_p0 - rptr_p0;
   assign wr_acc = bus.wen && !full && reset;
   assign rd_acc = bus.ren && !empty && reset;
   assign head   = mem[rptr_p0[AW-1:0]];

   always_ff @(posedge clk) begin
      if (wr_acc)
         mem[wptr_p0[AW-1:0]] <= bus.din;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr_p0 <= '0;
         rptr_p0 <= '0;
      end else begin
         if (wr_acc) wptr_p0 <= wptr_p0 + 1'b1;
         if (rd_acc) rptr_p0 <= rptr_p0 + 1'b1;
      end
   end

   // Registered-read output stage; holds its value on idle or rejected reads.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         dout_p1 <= '0;
      else if (rd_acc)
         dout_p1 <= head;
   end

   // Sticky errors: a new error in the same cycle beats clr_err.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf_p0 <= 1'b0;
         udf_p0 <= 1'b0;
      end else begin
         if (bus.wen && full)   ovf_p0 <= 1'b1;
         else if (bus.clr_err)  ovf_p0 <= 1'b0;
         if (bus.ren && empty)  udf_p0 <= 1'b1;
         else if (bus.clr_err)  udf_p0 <= 1'b0;
      end
   end

   assign bus.dout         = (FWFT != 0) ? (empty ? '0 : head) : dout_p1;
   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.count        = count;
   assign bus.almost_full  = (count >= AFULL_C);
   assign bus.almost_empty = (count <= AEMPTY_C);
   assign bus.overflow     = ovf_p0;
   assign bus.underflow    = udf_p0;
endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a registered-read and an FWFT instance share one
// stimulus stream and are compared every cycle against a queue-based model.
module tb_sync_fifo;
   localparam int DEPTH = 8;
   localparam int WIDTH = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic wen = 1'b0, ren = 1'b0, clr = 1'b0;
   logic [WIDTH-1:0] din = '0;

   int n_total = 0;
   int n_pass  = 0;
   bit cmp_on  = 1'b0;

   sync_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if0 ();
   sync_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if1 ();

   assign if0.wen = wen;  assign if0.din = din;  assign if0.ren = ren;  assign if0.clr_err = clr;
   assign if1.wen = wen;  assign if1.din = din;  assign if1.ren = ren;  assign if1.clr_err = clr;

   sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(0)) dut0 (.clk(clk), .reset(rst_n), .bus(if0));
   sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(1)) dut1 (.clk(clk), .reset(rst_n), .bus(if1));

   always #5 clk = ~clk;

   // Reference model: contents as a queue, errors as bits, registered dout as a byte.
   logic [WIDTH-1:0] q[$];
   bit               m_ovf = 1'b0, m_udf = 1'b0;
   logic [WIDTH-1:0] m_dout0 = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_ovf   = 1'b0;
         m_udf   = 1'b0;
         m_dout0 = '0;
      end else begin
         automatic bit was_full  = (q.size() == DEPTH);
         automatic bit was_empty = (q.size() == 0);
         if (wen && was_full)  m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
         if (ren && was_empty) m_udf = 1'b1; else if (clr) m_udf = 1'b0;
         if (ren && !was_empty) m_dout0 = q.pop_front();
         if (wen && !was_full)  q.push_back(din);
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Per-cycle compare of both instances against the model.
   always @(negedge clk) begin
      if (cmp_on) begin
         automatic int sz = q.size();
         automatic logic [WIDTH-1:0] hd = (sz != 0) ? q[0] : '0;
         chk("m0.count", 64'(if0.count), 64'(sz));
         chk("m0.empty", 64'(if0.empty), 64'(sz == 0));
         chk("m0.full",  64'(if0.full),  64'(sz == DEPTH));
         chk("m0.afull", 64'(if0.almost_full),  64'(sz >= DEPTH - 2));
         chk("m0.aempty",64'(if0.almost_empty), 64'(sz <= 2));
         chk("m0.ovf",   64'(if0.overflow),  64'(m_ovf));
         chk("m0.udf",   64'(if0.underflow), 64'(m_udf));
         chk("m0.dout",  64'(if0.dout), 64'(m_dout0));
         chk("m1.count", 64'(if1.count), 64'(sz));
         chk("m1.ovf",   64'(if1.overflow),  64'(m_ovf));
         chk("m1.udf",   64'(if1.underflow), 64'(m_udf));
         chk("m1.dout",  64'(if1.dout), 64'(hd));
      end
   end

   // Apply one cycle of inputs; returns just after the following falling edge.
   task automatic cyc(input bit w, input logic [WIDTH-1:0] d, input bit r, input bit c);
      wen = w; din = d; ren = r; clr = c;
      @(negedge clk); #1;
   endtask

   initial begin
      @(negedge clk); #1;
      cyc(0, 0, 0, 0);
      chk("rst.count", 64'(if0.count), 64'd0);
      chk("rst.empty", 64'(if0.empty), 64'd1);
      rst_n = 1'b1;
      cmp_on = 1'b1;
      cyc(0, 0, 0, 0);
      chk("idle.empty",  64'(if0.empty), 64'd1);
      chk("idle.full",   64'(if0.full), 64'd0);
      chk("idle.aempty", 64'(if0.almost_empty), 64'd1);
      chk("idle.dout",   64'(if0.dout), 64'd0);
      chk("idle.errs",   64'({if0.overflow, if0.underflow}), 64'd0);

      // Fill 0x01..0x08
      for (int i = 1; i <= 8; i++) begin
         cyc(1, 8'(i), 0, 0);
         chk("fill.count", 64'(if0.count), 64'(i));
         chk("fill.afull", 64'(if0.almost_full), 64'(i >= 6));
      end
      chk("fill.full", 64'(if0.full), 64'd1);
      chk("fill.head1", 64'(if1.dout), 64'h01);

      cyc(1, 8'hAA, 0, 0);
      chk("ovf.set", 64'(if0.overflow), 64'd1);
      chk("ovf.count", 64'(if0.count), 64'd8);

      for (int i = 1; i <= 8; i++) begin
         cyc(0, 0, 1, 0);
         chk("drain.dout0", 64'(if0.dout), 64'(i));
      end
      chk("drain.empty", 64'(if0.empty), 64'd1);
      chk("drain.dout1", 64'(if1.dout), 64'd0);

      cyc(0, 0, 1, 0);
      chk("udf.set",  64'(if0.underflow), 64'd1);
      chk("udf.dout", 64'(if0.dout), 64'h08);

      cyc(0, 0, 0, 1);
      chk("clr.errs", 64'({if0.overflow, if0.underflow}), 64'd0);

      for (int i = 0; i < 8; i++) cyc(1, 8'h20 + 8'(i), 0, 0);
      cyc(1, 8'hBB, 0, 1);
      chk("ovf.setwins", 64'(if0.overflow), 64'd1);
      cyc(0, 0, 0, 1);
      chk("ovf.cleared", 64'(if0.overflow), 64'd0);
      for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0);
      chk("drain2.dout0", 64'(if0.dout), 64'h27);

      // FWFT single-word fall-through
      cyc(1, 8'h5A, 0, 0);
      chk("fwft.dout",  64'(if1.dout), 64'h5A);
      chk("fwft.empty", 64'(if1.empty), 64'd0);
      cyc(0, 0, 1, 0);
      chk("fwft.empty2", 64'(if1.empty), 64'd1);
      chk("fwft.dout2",  64'(if1.dout), 64'd0);

      // Steady state at count 4 across pointer wrap
      for (int i = 0; i < 4; i++) cyc(1, 8'h10 + 8'(i), 0, 0);
      for (int i = 0; i < 20; i++) begin
         cyc(1, 8'h14 + 8'(i), 1, 0);
         chk("wrap.count", 64'(if0.count), 64'd4);
         chk("wrap.dout0", 64'(if0.dout), 64'(8'h10 + 8'(i)));
      end
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0);
      chk("wrap.tail", 64'(if0.dout), 64'h27);

      // Asynchronous reset while holding five words
      for (int i = 0; i < 5; i++) cyc(1, 8'h40 + 8'(i), 0, 0);
      chk("pre.count", 64'(if0.count), 64'd5);
      #2 rst_n = 1'b0;
      #1;
      chk("arst.count", 64'(if0.count), 64'd0);
      chk("arst.empty", 64'(if1.empty), 64'd1);
      chk("arst.dout0", 64'(if0.dout), 64'd0);
      @(negedge clk); #1;
      cyc(0, 0, 0, 0);
      rst_n = 1'b1;
      cyc(0, 0, 0, 0);
      chk("post.empty", 64'(if0.empty), 64'd1);
      cyc(0, 0, 1, 0);
      chk("post.dout0", 64'(if0.dout), 64'd0);
      chk("post.dout1", 64'(if1.dout), 64'd0);
      chk("post.udf",   64'(if0.underflow), 64'd1);

      cmp_on = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
